// File: rtl/text_console_writer_pkg.sv
// rtl/text_console_writer_pkg.sv - shared constants and types for the text console writer
// Purpose: control codes, default blank code, FSM state encoding and cursor operations.
// Ports: none (package).
package console_pkg;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] BLANK_CODE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLR_LINE   = 2'd1,
        ST_CLR_SCREEN = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_INC  = 3'd1,
        OP_DEC  = 3'd2,
        OP_CR   = 3'd3,
        OP_NL   = 3'd4,
        OP_HOME = 3'd5
    } cur_op_e;

endpackage

// File: rtl/text_console_writer_if.sv
// rtl/text_console_writer_if.sv - character stream and RAM write port bundle
// Purpose: groups the incoming character handshake and the text RAM write port.
// Ports: char_in/char_valid/char_ready (stream), din/write_en/waddr (RAM write port).
//   master: stream producer / RAM side; slave: the console writer.
interface text_console_writer_if #(
    parameter int data_width = 8,
    parameter int addr_width = 11
);
    logic [data_width-1:0] char_in;
    logic                  char_valid;
    logic                  char_ready;
    logic [data_width-1:0] din;
    logic                  write_en;
    logic [addr_width-1:0] waddr;

    modport master (
        output char_in, char_valid,
        input  char_ready, din, write_en, waddr
    );

    modport slave (
        input  char_in, char_valid,
        output char_ready, din, write_en, waddr
    );
endinterface

// File: rtl/text_console_writer_cursor_counter.sv
// rtl/text_console_writer_cursor_counter.sv - cursor column/row and line base register
// Purpose: holds col, row and line_base (row*cols, kept by stepping, no multiplier).
// Ports: wclk, rstn (async active-low), i_op (cursor operation),
//   o_col, o_row, o_line_base.
module cursor_counter
    import console_pkg::*;
#(
    parameter int cols       = 40,
    parameter int rows       = 30,
    parameter int addr_width = $clog2(rows*cols)
) (
    input  logic                      wclk,
    input  logic                      rstn,
    input  cur_op_e                   i_op,
    output logic [$clog2(cols)-1:0]   o_col,
    output logic [$clog2(rows)-1:0]   o_row,
    output logic [addr_width-1:0]     o_line_base
);

    localparam int COL_W = $clog2(cols);
    localparam int ROW_W = $clog2(rows);

    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [addr_width-1:0] r_line_base;

    logic                  w_row_last;
    logic                  w_col_last;
    logic [ROW_W-1:0]      w_next_row;
    logic [addr_width-1:0] w_next_base;

    assign w_row_last  = (r_row == ROW_W'(rows-1));
    assign w_col_last  = (r_col == COL_W'(cols-1));
    // Newline advance wraps the last row back to the top of the RAM.
    assign w_next_row  = w_row_last ? '0 : r_row + ROW_W'(1);
    assign w_next_base = w_row_last ? '0 : r_line_base + addr_width'(cols);

    always_ff @(posedge wclk or negedge rstn) begin
        if (!rstn) begin
            r_col       <= '0;
            r_row       <= '0;
            r_line_base <= '0;
        end else begin
            case (i_op)
                OP_INC: begin
                    if (w_col_last) begin
                        r_col       <= '0;
                        r_row       <= w_next_row;
                        r_line_base <= w_next_base;
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                OP_DEC: begin
                    if (r_col != '0) begin
                        r_col <= r_col - COL_W'(1);
                    end
                end
                OP_CR: begin
                    r_col <= '0;
                end
                OP_NL: begin
                    r_col       <= '0;
                    r_row       <= w_next_row;
                    r_line_base <= w_next_base;
                end
                OP_HOME: begin
                    r_col       <= '0;
                    r_row       <= '0;
                    r_line_base <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_col       = r_col;
    assign o_row       = r_row;
    assign o_line_base = r_line_base;

endmodule

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - character stream to video text RAM write port
// Purpose: consumes characters/control codes, keeps the cursor, writes the text RAM,
//   clears a line on newline and the whole screen on request.
// Ports: wclk, rstn (async active-low), bus (slave: char stream + RAM write port),
//   clear_req, busy, cursor_col, cursor_row.
module text_console_writer
    import console_pkg::*;
#(
    parameter int                    cols           = 40,
    parameter int                    rows           = 30,
    parameter int                    addr_width     = $clog2(rows*cols),
    parameter int                    data_width     = 8,
    parameter logic [data_width-1:0] BLANK          = data_width'(BLANK_CODE),
    parameter int                    CLEAR_ON_RESET = 1
) (
    input  logic                     wclk,
    input  logic                     rstn,
    text_console_writer_if.slave     bus,
    input  logic                     clear_req,
    output logic                     busy,
    output logic [$clog2(cols)-1:0]  cursor_col,
    output logic [$clog2(rows)-1:0]  cursor_row
);

    localparam int COL_W = $clog2(cols);
    localparam int ROW_W = $clog2(rows);

    localparam logic [1:0] IDLE       = ST_IDLE;
    localparam logic [1:0] CLR_LINE   = ST_CLR_LINE;
    localparam logic [1:0] CLR_SCREEN = ST_CLR_SCREEN;

    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(rows*cols-1);
    localparam logic [data_width-1:0] C_CR      = data_width'(CHAR_CR);
    localparam logic [data_width-1:0] C_LF      = data_width'(CHAR_LF);
    localparam logic [data_width-1:0] C_BS      = data_width'(CHAR_BS);
    localparam logic [data_width-1:0] C_FF      = data_width'(CHAR_FF);
    localparam logic [data_width-1:0] C_FIRST   = data_width'(8'h20);
    localparam logic [data_width-1:0] C_LAST    = data_width'(8'h7E);

    logic [1:0]            r_state;
    logic                  r_started;
    logic                  r_pend;
    logic                  r_line_go;
    logic                  r_we;
    logic [addr_width-1:0] r_waddr;
    logic [data_width-1:0] r_din;

    logic [COL_W-1:0]      w_col;
    logic [ROW_W-1:0]      w_row;
    logic [addr_width-1:0] w_line_base;
    logic [addr_width-1:0] w_cur_addr;
    logic [addr_width-1:0] w_line_end;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_printable;
    logic                  w_col_last;
    logic                  w_line_done;
    logic                  w_go_screen;
    cur_op_e               w_op;

    cursor_counter #(
        .cols       (cols),
        .rows       (rows),
        .addr_width (addr_width)
    ) u_cursor (
        .wclk        (wclk),
        .rstn        (rstn),
        .i_op        (w_op),
        .o_col       (w_col),
        .o_row       (w_row),
        .o_line_base (w_line_base)
    );

    // r_started keeps char_ready low while in reset and for the first cycle
    // after release, which is when the automatic clear gets launched.
    assign w_ready     = r_started && (r_state == IDLE) && !clear_req;
    assign w_accept    = bus.char_valid && w_ready;
    assign w_printable = (bus.char_in >= C_FIRST) && (bus.char_in <= C_LAST);
    assign w_col_last  = (w_col == COL_W'(cols-1));
    assign w_cur_addr  = w_line_base + addr_width'(w_col);
    assign w_line_end  = w_line_base + addr_width'(cols-1);
    assign w_line_done = (r_state == CLR_LINE) && r_line_go && (r_waddr == w_line_end);

    assign w_go_screen = ((r_state == IDLE) &&
                          ((!r_started && (CLEAR_ON_RESET != 0)) ||
                           (r_started && clear_req) ||
                           (w_accept && (bus.char_in == C_FF)))) ||
                         (w_line_done && (r_pend || clear_req));

    always_comb begin
        w_op = OP_NONE;
        if ((r_state == IDLE) && w_accept) begin
            if (w_printable) begin
                w_op = OP_INC;
            end else if (bus.char_in == C_LF) begin
                w_op = OP_NL;
            end else if (bus.char_in == C_CR) begin
                w_op = OP_CR;
            end else if (bus.char_in == C_BS) begin
                w_op = OP_DEC;
            end
        end else if ((r_state == CLR_SCREEN) && (r_waddr == LAST_ADDR)) begin
            w_op = OP_HOME;
        end
    end

    // The write port is registered; in the clear states r_waddr doubles as the
    // sweep counter, so write_en is high exactly while the blank sweep runs.
    always_ff @(posedge wclk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_started <= 1'b0;
            r_pend    <= 1'b0;
            r_line_go <= 1'b0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_din     <= '0;
        end else begin
            r_started <= 1'b1;
            r_we      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            r_we    <= 1'b1;
                            r_din   <= bus.char_in;
                            r_waddr <= w_cur_addr;
                            // The character goes out first; the line sweep
                            // starts on the following cycle.
                            if (w_col_last) begin
                                r_state   <= CLR_LINE;
                                r_line_go <= 1'b0;
                            end
                        end else if (bus.char_in == C_LF) begin
                            r_state   <= CLR_LINE;
                            r_line_go <= 1'b0;
                        end else if ((bus.char_in == C_BS) && (w_col != '0)) begin
                            r_we    <= 1'b1;
                            r_din   <= BLANK;
                            r_waddr <= w_cur_addr - addr_width'(1);
                        end
                    end
                end
                CLR_LINE: begin
                    if (clear_req) begin
                        r_pend <= 1'b1;
                    end
                    if (!r_line_go) begin
                        r_line_go <= 1'b1;
                        r_we      <= 1'b1;
                        r_din     <= BLANK;
                        r_waddr   <= w_line_base;
                    end else if (w_line_done) begin
                        r_state <= IDLE;
                    end else begin
                        r_we    <= 1'b1;
                        r_waddr <= r_waddr + addr_width'(1);
                    end
                end
                CLR_SCREEN: begin
                    if (r_waddr == LAST_ADDR) begin
                        r_state <= IDLE;
                    end else begin
                        r_we    <= 1'b1;
                        r_waddr <= r_waddr + addr_width'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (w_go_screen) begin
                r_state <= CLR_SCREEN;
                r_we    <= 1'b1;
                r_din   <= BLANK;
                r_waddr <= '0;
                r_pend  <= 1'b0;
            end
        end
    end

    assign bus.char_ready = w_ready;
    assign bus.din        = r_din;
    assign bus.write_en   = r_we;
    assign bus.waddr      = r_waddr;
    assign busy           = (r_state != IDLE);
    assign cursor_col     = w_col;
    assign cursor_row     = w_row;

endmodule

// File: tb/tb_text_console_writer.sv
// tb/tb_text_console_writer.sv - directed self-checking bench for text_console_writer
module tb_text_console_writer;

    logic       wclk = 1'b0;
    logic       rstn = 1'b0;
    logic       clear_req = 1'b0;
    logic       busy;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;

    int checks = 0;
    int errors = 0;

    int nb, fa, la, nbusy, nrdy, noth, oa, gp;

    text_console_writer_if #(.data_width(8), .addr_width(11)) bus ();

    text_console_writer dut (
        .wclk       (wclk),
        .rstn       (rstn),
        .bus        (bus),
        .clear_req  (clear_req),
        .busy       (busy),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 wclk = ~wclk;

    task automatic send_char(input logic [7:0] c);
        int n;
        @(negedge wclk);
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        n = 0;
        while (!bus.char_ready && n < 3000) begin
            @(negedge wclk);
            n++;
        end
        if (!bus.char_ready) begin
            checks++;
            errors++;
            $display("FAIL send_char_timeout char=%h char_ready=%b expected 1", c, bus.char_ready);
        end
        @(posedge wclk);
        #1;
        bus.char_valid = 1'b0;
    endtask

    // Observes one busy period starting at the next falling edge.
    task automatic run_until_idle(output int n_blank, output int first_a, output int last_a,
                                  output int n_busy, output int n_ready, output int n_other,
                                  output int other_a, output int gaps);
        bit seen;
        int prev;
        n_blank = 0; first_a = -1; last_a = -1; n_busy = 0; n_ready = 0;
        n_other = 0; other_a = -1; gaps = 0; seen = 0; prev = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge wclk);
            if (!busy && seen) break;
            if (busy) begin
                seen = 1;
                n_busy++;
                if (bus.char_ready) n_ready++;
            end
            if (bus.write_en) begin
                if (bus.din === 8'h20) begin
                    if (n_blank == 0) first_a = int'(bus.waddr);
                    else if (int'(bus.waddr) != prev + 1) gaps++;
                    prev   = int'(bus.waddr);
                    last_a = int'(bus.waddr);
                    n_blank++;
                end else begin
                    n_other++;
                    other_a = int'(bus.waddr);
                end
            end
        end
        if (busy || !seen) begin
            checks++;
            errors++;
            $display("FAIL busy_period_timeout busy=%b seen=%0d expected busy to end", busy, seen);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_req = 1'b0;
        bus.char_valid = 1'b0;
        bus.char_in = 8'h00;
        repeat (3) @(negedge wclk);
        checks++;
        if ({busy, bus.char_ready, bus.write_en, bus.waddr, bus.din, cursor_row, cursor_col} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b rdy=%b we=%b waddr=%0d din=%h row=%0d col=%0d expected all 0",
                     busy, bus.char_ready, bus.write_en, bus.waddr, bus.din, cursor_row, cursor_col);
        end
        rstn = 1'b1;
        run_until_idle(nb, fa, la, nbusy, nrdy, noth, oa, gp);
        checks++;
        if (nb !== 1200 || fa !== 0 || la !== 1199 || gp !== 0 || noth !== 0) begin
            errors++;
            $display("FAIL auto_clear_writes blanks=%0d first=%0d last=%0d gaps=%0d other=%0d expected 1200 0 1199 0 0",
                     nb, fa, la, gp, noth);
        end
        checks++;
        if (nbusy !== 1200 || nrdy !== 0) begin
            errors++;
            $display("FAIL auto_clear_busy busy_cycles=%0d ready_cycles=%0d expected 1200 0", nbusy, nrdy);
        end
        checks++;
        if (bus.char_ready !== 1'b1 || bus.write_en !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL after_auto_clear rdy=%b we=%b row=%0d col=%0d expected 1 0 0 0",
                     bus.char_ready, bus.write_en, cursor_row, cursor_col);
        end
    endtask

    task automatic test_single_char();
        send_char(8'h41);
        @(negedge wclk);
        checks++;
        if (bus.write_en !== 1'b1 || bus.waddr !== 11'd0 || bus.din !== 8'h41) begin
            errors++;
            $display("FAIL char_A_write we=%b waddr=%0d din=%h expected 1 0 41", bus.write_en, bus.waddr, bus.din);
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd1) begin
            errors++;
            $display("FAIL char_A_cursor row=%0d col=%0d expected 0 1", cursor_row, cursor_col);
        end
        @(negedge wclk);
        checks++;
        if (bus.write_en !== 1'b0 || bus.waddr !== 11'd0 || bus.din !== 8'h41) begin
            errors++;
            $display("FAIL char_A_single_cycle we=%b waddr=%0d din=%h expected 0 0 41", bus.write_en, bus.waddr, bus.din);
        end
        send_char(8'h0D);
        @(negedge wclk);
        checks++;
        if (bus.write_en !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL cr_home we=%b row=%0d col=%0d expected 0 0 0", bus.write_en, cursor_row, cursor_col);
        end
    endtask

    task automatic test_line_wrap();
        int bad;
        logic [7:0] c;
        bad = 0;
        for (int i = 0; i < 39; i++) begin
            c = 8'(8'h30 + i % 10);
            send_char(c);
            @(negedge wclk);
            if (!(bus.write_en === 1'b1 && int'(bus.waddr) == i && bus.din === c)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL row0_char_writes bad_writes=%0d expected 0", bad);
        end
        send_char(8'h2E);
        run_until_idle(nb, fa, la, nbusy, nrdy, noth, oa, gp);
        checks++;
        if (noth !== 1 || oa !== 39) begin
            errors++;
            $display("FAIL col39_char_write writes=%0d addr=%0d expected 1 39", noth, oa);
        end
        checks++;
        if (nb !== 40 || fa !== 40 || la !== 79 || gp !== 0 || nrdy !== 0 || nbusy !== 41) begin
            errors++;
            $display("FAIL wrap_clr_line blanks=%0d first=%0d last=%0d gaps=%0d ready=%0d busy=%0d expected 40 40 79 0 0 41",
                     nb, fa, la, gp, nrdy, nbusy);
        end
        send_char(8'h2F);
        @(negedge wclk);
        checks++;
        if (bus.write_en !== 1'b1 || bus.waddr !== 11'd40 || bus.din !== 8'h2F ||
            cursor_row !== 5'd1 || cursor_col !== 6'd1) begin
            errors++;
            $display("FAIL char41 we=%b waddr=%0d din=%h row=%0d col=%0d expected 1 40 2f 1 1",
                     bus.write_en, bus.waddr, bus.din, cursor_row, cursor_col);
        end
    endtask

    task automatic test_backspace();
        send_char(8'h0D);
        send_char(8'h0A);
        run_until_idle(nb, fa, la, nbusy, nrdy, noth, oa, gp);
        send_char(8'h0A);
        run_until_idle(nb, fa, la, nbusy, nrdy, noth, oa, gp);
        checks++;
        if (nb !== 40 || fa !== 120 || la !== 159 || noth !== 0 || cursor_row !== 5'd3 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL lf_row3 blanks=%0d first=%0d last=%0d other=%0d row=%0d col=%0d expected 40 120 159 0 3 0",
                     nb, fa, la, noth, cursor_row, cursor_col);
        end
        send_char(8'h08);
        @(negedge wclk);
        checks++;
        if (bus.write_en !== 1'b0 || cursor_row !== 5'd3 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL bs_col0 we=%b row=%0d col=%0d expected 0 3 0", bus.write_en, cursor_row, cursor_col);
        end
        for (int i = 0; i < 7; i++) begin
            send_char(8'h78);
            @(negedge wclk);
        end
        send_char(8'h08);
        @(negedge wclk);
        checks++;
        if (bus.write_en !== 1'b1 || bus.waddr !== 11'd126 || bus.din !== 8'h20 ||
            cursor_row !== 5'd3 || cursor_col !== 6'd6) begin
            errors++;
            $display("FAIL bs_col7 we=%b waddr=%0d din=%h row=%0d col=%0d expected 1 126 20 3 6",
                     bus.write_en, bus.waddr, bus.din, cursor_row, cursor_col);
        end
        send_char(8'h01);
        @(negedge wclk);
        checks++;
        if (bus.write_en !== 1'b0 || busy !== 1'b0 || cursor_row !== 5'd3 || cursor_col !== 6'd6) begin
            errors++;
            $display("FAIL ignored_code we=%b busy=%b row=%0d col=%0d expected 0 0 3 6",
                     bus.write_en, busy, cursor_row, cursor_col);
        end
    endtask

    task automatic test_lf_wrap();
        for (int i = 0; i < 26; i++) begin
            send_char(8'h0A);
            run_until_idle(nb, fa, la, nbusy, nrdy, noth, oa, gp);
        end
        checks++;
        if (nb !== 40 || fa !== 1160 || la !== 1199 || gp !== 0 || cursor_row !== 5'd29 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL last_row_clear blanks=%0d first=%0d last=%0d gaps=%0d row=%0d col=%0d expected 40 1160 1199 0 29 0",
                     nb, fa, la, gp, cursor_row, cursor_col);
        end
        for (int i = 0; i < 5; i++) begin
            send_char(8'h6B);
            @(negedge wclk);
        end
        checks++;
        if (cursor_row !== 5'd29 || cursor_col !== 6'd5) begin
            errors++;
            $display("FAIL cursor_29_5 row=%0d col=%0d expected 29 5", cursor_row, cursor_col);
        end
        send_char(8'h0A);
        run_until_idle(nb, fa, la, nbusy, nrdy, noth, oa, gp);
        checks++;
        if (nb !== 40 || fa !== 0 || la !== 39 || gp !== 0 || cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL lf_wrap_top blanks=%0d first=%0d last=%0d gaps=%0d row=%0d col=%0d expected 40 0 39 0 0 0",
                     nb, fa, la, gp, cursor_row, cursor_col);
        end
    endtask

    task automatic test_clear_priority();
        send_char(8'h71);
        @(negedge wclk);
        send_char(8'h71);
        @(negedge wclk);
        @(negedge wclk);
        clear_req = 1'b1;
        bus.char_in = 8'h5A;
        bus.char_valid = 1'b1;
        #1;
        checks++;
        if (bus.char_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_req_blocks_ready rdy=%b expected 0", bus.char_ready);
        end
        @(posedge wclk);
        #1;
        clear_req = 1'b0;
        bus.char_valid = 1'b0;
        run_until_idle(nb, fa, la, nbusy, nrdy, noth, oa, gp);
        checks++;
        if (nb !== 1200 || fa !== 0 || la !== 1199 || gp !== 0 || noth !== 0 || nbusy !== 1200) begin
            errors++;
            $display("FAIL clear_screen blanks=%0d first=%0d last=%0d gaps=%0d other=%0d busy=%0d expected 1200 0 1199 0 0 1200",
                     nb, fa, la, gp, noth, nbusy);
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd0 || bus.char_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_screen_home row=%0d col=%0d rdy=%b expected 0 0 1", cursor_row, cursor_col, bus.char_ready);
        end
    endtask

    task automatic test_clear_during_line();
        send_char(8'h0A);
        @(negedge wclk);
        clear_req = 1'b1;
        @(posedge wclk);
        #1;
        clear_req = 1'b0;
        run_until_idle(nb, fa, la, nbusy, nrdy, noth, oa, gp);
        checks++;
        if (nb !== 1240 || nbusy !== 1240 || fa !== 40 || la !== 1199 || noth !== 0) begin
            errors++;
            $display("FAIL latched_clear blanks=%0d busy=%0d first=%0d last=%0d other=%0d expected 1240 1240 40 1199 0",
                     nb, nbusy, fa, la, noth);
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL latched_clear_home row=%0d col=%0d expected 0 0", cursor_row, cursor_col);
        end
    endtask

    task automatic test_reset_mid_clear();
        send_char(8'h0C);
        repeat (100) @(negedge wclk);
        checks++;
        if (busy !== 1'b1 || bus.write_en !== 1'b1 || bus.waddr !== 11'd99) begin
            errors++;
            $display("FAIL ff_clear_running busy=%b we=%b waddr=%0d expected 1 1 99", busy, bus.write_en, bus.waddr);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy, bus.char_ready, bus.write_en, bus.waddr, bus.din, cursor_row, cursor_col} !== '0) begin
            errors++;
            $display("FAIL reset_mid_clear busy=%b rdy=%b we=%b waddr=%0d din=%h row=%0d col=%0d expected all 0",
                     busy, bus.char_ready, bus.write_en, bus.waddr, bus.din, cursor_row, cursor_col);
        end
        repeat (2) @(negedge wclk);
        rstn = 1'b1;
        run_until_idle(nb, fa, la, nbusy, nrdy, noth, oa, gp);
        checks++;
        if (nb !== 1200 || fa !== 0 || la !== 1199 || gp !== 0 || nbusy !== 1200) begin
            errors++;
            $display("FAIL restart_clear blanks=%0d first=%0d last=%0d gaps=%0d busy=%0d expected 1200 0 1199 0 1200",
                     nb, fa, la, gp, nbusy);
        end
        checks++;
        if (bus.char_ready !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL restart_idle rdy=%b row=%0d col=%0d expected 1 0 0", bus.char_ready, cursor_row, cursor_col);
        end
    endtask

    initial begin
        bus.char_in = 8'h00;
        bus.char_valid = 1'b0;
        test_reset();
        test_single_char();
        test_line_wrap();
        test_backspace();
        test_lf_wrap();
        test_clear_priority();
        test_clear_during_line();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Write-side producer for the dual-port video text RAM. Consumes a byte stream of ASCII characters and control codes.
- Maintains a cursor and drives the RAM write port (`din`, `write_en`, `waddr`) on the same clock.
- Handles newline, carriage return, backspace and clear-screen. On reaching the last row it wraps to the top and blanks the new line. The video reader on `rclk` is unaffected.

Parameters:
- cols, 40, text columns per row
- rows, 30, text rows
- addr_width, $clog2(rows*cols), RAM address width (must match the RAM instance)
- data_width, 8, character code width
- BLANK, 8'h20, fill code for clears and backspace
- CLEAR_ON_RESET, 1, when 1 a full-screen clear runs automatically after reset release

Ports:
- wclk  in  1  clock, shared with RAM write port
- rstn  in  1  asynchronous active-low reset
- char_in  in  data_width  incoming character/control code
- char_valid  in  1  char_in valid
- char_ready  out  1  block can accept char_in this cycle
- clear_req  in  1  single-cycle request: clear screen and home cursor
- busy  out  1  high while a line/screen clear is in progress
- cursor_col  out  $clog2(cols)  current column
- cursor_row  out  $clog2(rows)  current row
- din  out  data_width  RAM write data
- write_en  out  1  RAM write enable
- waddr  out  addr_width  RAM write address

Behaviour:
- Reset (async, rstn low): all outputs 0 (`char_ready`, `busy`, `write_en`, `waddr`, `din`, cursor). `line_base` = 0. State = IDLE, or CLR_SCREEN on release if CLEAR_ON_RESET = 1.
- Reset mid-clear: aborts immediately. RAM may be partially cleared; the auto-clear restarts after release if enabled.
- Address rule: `waddr` = `line_base` + `cursor_col`.
  - `line_base` is a register stepped by +cols / reset to 0. No multiplier.
  - Max address is rows*cols-1; never exceeded.
- Handshake: `char_ready` = (state == IDLE) && !`clear_req`. A transfer occurs when `char_valid` && `char_ready`. `char_in` is sampled once per transfer.
- States and transitions:
  - IDLE
    - `clear_req` → CLR_SCREEN. It has priority over a simultaneous `char_valid`; the char is not accepted.
    - Accepted char → action below, performed in the same edge.
  - Printable char (0x20..0x7E): registered write next cycle.
    - `write_en`=1, `din`=char, `waddr`=cursor address. Latency: accept edge N → `write_en` high for cycle N+1 only.
    - Cursor col+1. If col was cols-1 → col 0 and newline advance.
  - 0x0D CR: col=0, no write.
  - 0x0A LF: col=0, newline advance.
  - 0x08 BS: if col>0 → col-1 and write BLANK at the new position. If col=0, no-op (no row change).
  - 0x0C FF: same as `clear_req`.
  - Other codes: ignored, no write, `char_ready` stays high.
  - Newline advance: row+1 and `line_base`+=cols. If row was rows-1 → row 0, `line_base`=0. Then enter CLR_LINE.
  - CLR_LINE
    - Writes BLANK at `line_base`+0 .. `line_base`+cols-1, one per cycle: exactly cols `write_en` cycles.
    - `busy`=1, `char_ready`=0.
    - Returns to IDLE with col=0; row unchanged.
    - `clear_req` during CLR_LINE is latched and serviced on completion (→ CLR_SCREEN).
  - CLR_SCREEN
    - Writes BLANK at addresses 0..rows*cols-1 sequentially: rows*cols `write_en` cycles.
    - `busy`=1. Ends with cursor (0,0), `line_base`=0, state IDLE.
    - `clear_req` during CLR_SCREEN is ignored.
- `write_en` is never asserted in IDLE except the single post-accept write cycle.
- `din`/`waddr` hold their last value when `write_en`=0.

Decomposition:
- Shared package `console_pkg`:
  - Control-code constants: CR 8'h0D, LF 8'h0A, BS 8'h08, FF 8'h0C.
  - BLANK default.
  - State enum: IDLE, CLR_LINE, CLR_SCREEN.
- One sub-module is natural: `cursor_counter`, holding col/row/`line_base` with increment, decrement, newline and home operations.
- The FSM and write-port register stay in `text_console_writer`.

Test Plan:
- Reset with CLEAR_ON_RESET=1, release → `busy` high for exactly 1200 cycles; addresses 0..1199 written with 8'h20; then `char_ready`=1, cursor (0,0).
- Send 'A' (8'h41) at (0,0) → next cycle `write_en`=1, `waddr`=0, `din`=8'h41; cursor (0,1).
- Send 41 printable chars from (0,0):
  - 40th char wraps → CLR_LINE writes 20h to 40..79 (40 cycles, `char_ready`=0).
  - 41st char written at `waddr`=40; cursor (1,1).
- Cursor at (29,5), send LF → wrap to row 0; CLR_LINE blanks 0..39; cursor (0,0).
- Cursor (3,0), send BS → no write, cursor unchanged. Cursor (3,7), send BS → write 20h at `waddr`=126; cursor (3,6).
- `clear_req` and `char_valid`('Z') asserted in same cycle → 'Z' not accepted, CLR_SCREEN runs. Assert rstn low mid-clear → outputs 0 immediately, clear restarts after release.
